dpbram_v2: RTL and testbench
============================

Name: dpbram_v2

Overview:
- Next-generation single-clock true dual-port block RAM for the memory subsystem.
- Adds per-byte write enables, a configurable read pipeline depth, a selectable read-during-write mode, and defined same-address collision arbitration with a flag.
- Adds a post-reset zero-fill sequencer, so downstream merge logic always sees deterministic memory contents.
- Both ports are symmetric except that port A has priority in collisions.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, read latency in cycles: 1 = array output register only, 2 = extra output register.
- RDW_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = ready immediately, contents undefined.

Ports:
- clk, input, 1, single clock for both ports.
- rst_n, input, 1, asynchronous active-low reset.
- en_a, input, 1, port A access enable.
- we_a, input, 1, port A write (valid only with en_a).
- be_a, input, NB, port A byte-lane write enables.
- addr_a, input, ADDR_WIDTH, port A address.
- din_a, input, DATA_WIDTH, port A write data.
- dout_a, output, DATA_WIDTH, port A read data.
- dvalid_a, output, 1, dout_a holds data for a read issued RD_LATENCY cycles earlier.
- en_b, we_b, be_b, addr_b, din_b, dout_b, dvalid_b: identical to port A, for port B.
- collision, output, 1, one-cycle pulse: same-address conflict detected.
- init_done, output, 1, high when ports accept accesses.

Behaviour:
- Reset (rst_n=0, asynchronous): dout_a, dout_b = 0; dvalid_a, dvalid_b = 0; collision = 0; all pipeline stages flushed. init_done = 0 if CLEAR_ON_RESET=1, otherwise 1. The memory array itself is not reset asynchronously.
- FSM states: CLEAR and READY. Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR: an internal counter writes 0 to address cnt each cycle, from 0 to 2^ADDR_WIDTH-1.
  - On the cycle after the last word is written, state becomes READY and init_done=1.
  - Clear takes exactly 2^ADDR_WIDTH cycles after reset release.
  - While in CLEAR, all port requests are ignored, dvalid stays 0 and collision stays 0.
  - Reset asserted mid-clear restarts the clear at address 0.
- Access (READY): a port is active when en=1.
  - Read: en=1, we=0.
  - Write: en=1, we=1. Lanes with be[i]=1 are written; we=1 with be=0 is a read for output purposes.
  - en=0: no access, and dout holds its last value.
- Latency: an access issued in cycle N drives dout and dvalid=1 at the clock edge ending cycle N+RD_LATENCY-1, i.e. they are visible during cycle N+RD_LATENCY.
  - dvalid is a per-cycle pulse tracking each issued read.
  - Back-to-back reads sustain 1 word/cycle per port.
- Same-port write, depending on RDW_MODE:
  - READ_FIRST: dout = old word, dvalid=1.
  - WRITE_FIRST: dout = merged new word (written lanes take din, others keep old data), dvalid=1.
  - NO_CHANGE: dout holds its previous value, dvalid=0.
- Cross-port, same address, same cycle:
  - Both writing: per lane, A wins where both be bits are set; lanes enabled only by B take din_b. collision=1.
  - One writing, one reading: the reader returns the old word (read-first across ports). collision=1.
  - Both reading: both return the word; collision=0.
  - A write with be=0 does not count as a write for collision purposes.
  - collision is registered and asserted in cycle N+1 for one cycle.
- Addresses wrap naturally modulo 2^ADDR_WIDTH; there are no out-of-range accesses.
- Synthesis: the array must infer block RAM. Collision merge logic sits outside the array.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> init_done=0 for 16 cycles after release, then 1. Reading addresses 0..15 returns 0x0000. An en_a write at cycle 3 is dropped (address still 0).
- RD_LATENCY=2: write A addr 5 = 0xBEEF with be=2'b11, then read A addr 5 at cycle N -> dout_a=0xBEEF and dvalid_a=1 in cycle N+2 only.
- Byte enables: addr 7 holds 0x1234; write 0xABCD with be_a=2'b01 -> read returns 0x12CD.
- RDW modes on addr 3 holding 0x1111, write 0x2222 with be=11:
  - READ_FIRST -> dout 0x1111.
  - WRITE_FIRST -> dout 0x2222.
  - NO_CHANGE -> dout unchanged, dvalid=0.
- Dual write to addr 9: A 0xAAAA with be=10, B 0xBBBB with be=11 -> word = 0xAABB; collision=1 in the next cycle. A reads addr 9 while B writes it -> A gets the old value, collision=1.
- Reset asserted mid-clear at cnt=6 -> outputs are 0 immediately; after release the clear restarts and init_done rises 16 cycles later.

Source files
------------

// File: rtl/dpbram_v2_if.sv
// dpbram_v2_if: one access port of the dual-port block RAM.
//
// One instance per port. The requester drives the access request and
// receives the read return.
//   master: drives en, we, be, addr, din; receives dout, dvalid
//   slave : receives en, we, be, addr, din; drives dout, dvalid
//
// Signals
//   en     access enable
//   we     write (qualified by en)
//   be     byte-lane write enables, NB = DATA_WIDTH/BYTE_WIDTH lanes
//   addr   word address
//   din    write data
//   dout   read data, holds its value between reads
//   dvalid one-cycle pulse, dout carries a freshly issued read
interface dpbram_v2_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
) ();
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dvalid;

    modport master (output en, we, be, addr, din, input dout, dvalid);
    modport slave  (input en, we, be, addr, din, output dout, dvalid);
endinterface

// File: rtl/dpbram_v2.sv
// dpbram_v2: single-clock true dual-port block RAM with byte enables.
//
// - Per-byte write enables; the array is split into NB byte-wide lanes so
//   each lane is a plain dual-port RAM with one write enable per port.
// - Read latency RD_LATENCY (1 or 2): 1 = array output register only,
//   2 = one extra output register.
// - Same-port read-during-write per RDW_MODE: 0 read-first, 1 write-first,
//   2 no-change (no read return on a write).
// - Same-address cross-port writes: port A wins on lanes both enable; the
//   arbitration masks port B's lane enables before they reach the array.
//   Cross-port reads see the old word. A same-address access where at least
//   one side really writes (be != 0) raises a one-cycle collision pulse.
// - CLEAR_ON_RESET=1: after reset a sequencer writes zero to every word,
//   one per cycle, through port A's array port; user requests are ignored
//   until init_done.
//
// Ports
//   clk        single clock for both ports
//   rst_n      asynchronous active-low reset (array contents not reset)
//   port_a     access port A (slave side), priority port
//   port_b     access port B (slave side)
//   collision  registered pulse, cycle after a same-address conflict
//   init_done  high once the ports accept accesses
module dpbram_v2 #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    dpbram_v2_if.slave  port_a,
    dpbram_v2_if.slave  port_b,
    output logic        collision,
    output logic        init_done
);
    localparam int NB     = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int STAGES = RD_LATENCY - 1;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  clr_act;
    logic                  ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET != 0) state <= S_CLEAR;
            else                     state <= S_READY;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_act   = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_act = 1'b1;
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                // last word written this cycle; ports open next cycle
                if (&cnt) state_nxt = S_READY;
            end
            default: ;
        endcase
    end

    assign ready     = (state == S_READY);
    assign init_done = ready;

    // ------------------------------------------------------------------
    // Request decode and cross-port arbitration
    // ------------------------------------------------------------------
    logic                  act_a, act_b;
    logic                  wr_a, wr_b;
    logic                  rd_a, rd_b;
    logic                  same_addr;
    logic [NB-1:0]         wl_a, wl_b;         // lanes each port asks to write
    logic [NB-1:0]         fw_a, fw_b;         // lanes returned from din (write-first)
    logic [NB-1:0]         arr_we_a, arr_we_b; // lane enables seen by the array
    logic [ADDR_WIDTH-1:0] arr_addr_a;
    logic [DATA_WIDTH-1:0] arr_din_a;

    always_comb begin
        act_a     = ready & port_a.en;
        act_b     = ready & port_b.en;
        // we with no lanes enabled behaves as a read everywhere
        wr_a      = port_a.we & (|port_a.be);
        wr_b      = port_b.we & (|port_b.be);
        same_addr = (port_a.addr == port_b.addr);

        wl_a = (act_a & port_a.we) ? port_a.be : '0;
        wl_b = (act_b & port_b.we) ? port_b.be : '0;

        // no-change mode suppresses the read return on a real write
        rd_a = act_a & ~((RDW_MODE == 2) & wr_a);
        rd_b = act_b & ~((RDW_MODE == 2) & wr_b);

        fw_a = (RDW_MODE == 1) ? wl_a : '0;
        fw_b = (RDW_MODE == 1) ? wl_b : '0;

        // the clear sequencer borrows port A's array port
        arr_we_a   = clr_act ? '1  : wl_a;
        arr_addr_a = clr_act ? cnt : port_a.addr;
        arr_din_a  = clr_act ? '0  : port_a.din;

        // A owns every lane it writes at a shared address
        arr_we_b = same_addr ? (wl_b & ~wl_a) : wl_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) collision <= 1'b0;
        else        collision <= act_a & act_b & same_addr & (wr_a | wr_b);
    end

    // ------------------------------------------------------------------
    // Byte lanes: one dual-port RAM per lane plus its output registers.
    // Reads are read-first by construction (old array word); write-first
    // substitutes the port's own din on the lanes it writes.
    // ------------------------------------------------------------------
    logic [NB-1:0][BYTE_WIDTH-1:0] q_a, q_b;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [BYTE_WIDTH-1:0] mem [DEPTH];
        logic [BYTE_WIDTH-1:0] q_a_r, q_b_r;

        always_ff @(posedge clk) begin
            if (arr_we_a[i]) mem[arr_addr_a]  <= arr_din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (arr_we_b[i]) mem[port_b.addr] <= port_b.din[i*BYTE_WIDTH +: BYTE_WIDTH];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_a_r <= '0;
                q_b_r <= '0;
            end else begin
                if (rd_a) q_a_r <= fw_a[i] ? port_a.din[i*BYTE_WIDTH +: BYTE_WIDTH]
                                           : mem[port_a.addr];
                if (rd_b) q_b_r <= fw_b[i] ? port_b.din[i*BYTE_WIDTH +: BYTE_WIDTH]
                                           : mem[port_b.addr];
            end
        end

        assign q_a[i] = q_a_r;
        assign q_b[i] = q_b_r;
    end

    // ------------------------------------------------------------------
    // Read-valid pipeline; stage 0 lines up with the array output register
    // ------------------------------------------------------------------
    logic [STAGES:0] vld_pipe_a, vld_pipe_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_a <= '0;
            vld_pipe_b <= '0;
        end else begin
            vld_pipe_a[0] <= rd_a;
            vld_pipe_b[0] <= rd_b;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe_a[k] <= vld_pipe_a[k-1];
                vld_pipe_b[k] <= vld_pipe_b[k-1];
            end
        end
    end

    assign port_a.dvalid = vld_pipe_a[STAGES];
    assign port_b.dvalid = vld_pipe_b[STAGES];

    // Optional extra output register (RD_LATENCY = 2). It loads only when a
    // read return passes through, so dout holds between reads.
    if (RD_LATENCY > 1) begin : g_oreg
        logic [DATA_WIDTH-1:0] oreg_a, oreg_b;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oreg_a <= '0;
                oreg_b <= '0;
            end else begin
                if (vld_pipe_a[0]) oreg_a <= q_a;
                if (vld_pipe_b[0]) oreg_b <= q_b;
            end
        end

        assign port_a.dout = oreg_a;
        assign port_b.dout = oreg_b;
    end else begin : g_noreg
        assign port_a.dout = q_a;
        assign port_b.dout = q_b;
    end
endmodule

// File: tb/tb_dpbram_v2.sv
// Bench for dpbram_v2. Three instances share one stimulus stream:
//   dut0: READ_FIRST,  RD_LATENCY 1
//   dut1: WRITE_FIRST, RD_LATENCY 2
//   dut2: NO_CHANGE,   RD_LATENCY 1
// All use ADDR_WIDTH 4, 16-bit words, 8-bit lanes, clear on reset.
// A word-level reference model predicts every read return per cycle.
module tb_dpbram_v2;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int NB = DW / BW;
    localparam int ND = 3;
    localparam int HL = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, we_a, en_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [ND-1:0][DW-1:0] doa_w, dob_w;
    logic [ND-1:0]         dva_w, dvb_w, coll_w, idn_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dpbram_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) pa ();
        dpbram_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) pb ();

        assign pa.en = en_a;  assign pa.we = we_a;  assign pa.be = be_a;
        assign pa.addr = addr_a;  assign pa.din = din_a;
        assign pb.en = en_b;  assign pb.we = we_b;  assign pb.be = be_b;
        assign pb.addr = addr_b;  assign pb.din = din_b;
        assign doa_w[g] = pa.dout;  assign dva_w[g] = pa.dvalid;
        assign dob_w[g] = pb.dout;  assign dvb_w[g] = pb.dvalid;

        dpbram_v2 #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
            .RD_LATENCY((g == 1) ? 2 : 1), .RDW_MODE(g), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .port_a(pa), .port_b(pb),
            .collision(coll_w[g]), .init_done(idn_w[g])
        );
    end

    // reference model state
    logic [DW-1:0] mem [16];
    bit            iv  [ND][2][HL];   // read return issued in cycle
    logic [DW-1:0] idt [ND][2][HL];   // its data
    bit            ic  [HL];          // conflict issued in cycle
    logic [DW-1:0] exp_do [ND][2];
    int rel;                          // clock edges since reset release
    int cyc;
    int n_chk, n_fail;

    function automatic int rl(input int g);
        return (g == 1) ? 2 : 1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) if (be[i]) r[i*BW +: BW] = d[i*BW +: BW];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply the memory rules to the inputs of the current cycle.
    task automatic issue();
        bit rdy, wa, wb;
        logic [DW-1:0] oa, ob;
        rdy = (rst_n === 1'b1) && (rel >= 16);
        wa  = en_a && we_a && (be_a != 0);
        wb  = en_b && we_b && (be_b != 0);
        oa  = mem[addr_a];
        ob  = mem[addr_b];
        ic[cyc] = rdy && en_a && en_b && (addr_a == addr_b) && (wa || wb);
        for (int g = 0; g < ND; g++) begin
            iv[g][0][cyc]  = rdy && en_a && !(g == 2 && wa);
            idt[g][0][cyc] = (g == 1 && wa) ? merge(oa, din_a, be_a) : oa;
            iv[g][1][cyc]  = rdy && en_b && !(g == 2 && wb);
            idt[g][1][cyc] = (g == 1 && wb) ? merge(ob, din_b, be_b) : ob;
        end
        // B first, then A on top: A owns lanes both ports write
        if (rdy && wb) mem[addr_b] = merge(mem[addr_b], din_b, be_b);
        if (rdy && wa) mem[addr_a] = merge(mem[addr_a], din_a, be_a);
    endtask

    task automatic check();
        int k;
        bit va, vb;
        for (int g = 0; g < ND; g++) begin
            k  = cyc - rl(g);
            va = (k >= 0) ? iv[g][0][k] : 1'b0;
            vb = (k >= 0) ? iv[g][1][k] : 1'b0;
            if (va) exp_do[g][0] = idt[g][0][k];
            if (vb) exp_do[g][1] = idt[g][1][k];
            chk($sformatf("c%0d dut%0d dvalid_a", cyc, g), DW'(dva_w[g]), DW'(va));
            chk($sformatf("c%0d dut%0d dout_a", cyc, g), doa_w[g], exp_do[g][0]);
            chk($sformatf("c%0d dut%0d dvalid_b", cyc, g), DW'(dvb_w[g]), DW'(vb));
            chk($sformatf("c%0d dut%0d dout_b", cyc, g), dob_w[g], exp_do[g][1]);
            chk($sformatf("c%0d dut%0d collision", cyc, g), DW'(coll_w[g]),
                DW'((cyc >= 1) ? ic[cyc-1] : 1'b0));
            chk($sformatf("c%0d dut%0d init_done", cyc, g), DW'(idn_w[g]),
                DW'((rst_n === 1'b1) && (rel >= 16)));
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked at the next one.
    task automatic step();
        issue();
        @(posedge clk);
        @(negedge clk);
        if (rst_n === 1'b1) rel++;
        if (rel == 16) foreach (mem[i]) mem[i] = '0;   // zero-fill just finished
        cyc++;
        check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rel = 0;
        for (int k = cyc - 2; k <= cyc; k++) begin
            if (k >= 0) begin
                ic[k] = 1'b0;
                for (int g = 0; g < ND; g++) begin
                    iv[g][0][k] = 1'b0;
                    iv[g][1][k] = 1'b0;
                end
            end
        end
        for (int g = 0; g < ND; g++) begin
            exp_do[g][0] = '0;
            exp_do[g][1] = '0;
        end
        check();
    endtask

    task automatic set_a(input logic e, input logic w, input logic [NB-1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        en_a = e; we_a = w; be_a = b; addr_a = a; din_a = d;
    endtask

    task automatic set_b(input logic e, input logic w, input logic [NB-1:0] b,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        en_b = e; we_b = w; be_b = b; addr_b = a; din_b = d;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rnd();
        set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 3)),
              AW'($urandom_range(0, 3)), DW'($urandom));
        set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 3)),
              AW'($urandom_range(0, 3)), DW'($urandom));
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            set_a(1'b1, 1'b0, '0, AW'(i), '0);
            set_b(1'b1, 1'b0, '0, AW'(15 - i), '0);
            step();
        end
        idle();
        repeat (2) step();
    endtask

    initial begin
        rst_n = 1'b0;
        n_chk = 0; n_fail = 0; cyc = 0; rel = 0;
        foreach (mem[i]) mem[i] = '0;
        idle();

        // power-up reset, then zero-fill with traffic that must be ignored
        @(negedge clk);
        do_reset();
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) set_a(1'b1, 1'b1, 2'b11, '0, 16'hFFFF);
            else        rnd();
            step();
        end
        chk("init_done after clear", DW'(idn_w[0]), 16'd1);
        sweep();

        // latency-2 read of a freshly written word
        set_a(1'b1, 1'b1, 2'b11, 4'd5, 16'hBEEF); step();
        idle(); repeat (2) step();
        set_a(1'b1, 1'b0, 2'b00, 4'd5, '0); step();
        chk("lat2 dvalid cycle N+1", DW'(dva_w[1]), 16'd0);
        idle(); step();
        chk("lat2 dvalid cycle N+2", DW'(dva_w[1]), 16'd1);
        chk("lat2 dout cycle N+2", doa_w[1], 16'hBEEF);
        step();
        chk("lat2 dvalid cycle N+3", DW'(dva_w[1]), 16'd0);

        // byte-lane write
        set_a(1'b1, 1'b1, 2'b11, 4'd7, 16'h1234); step();
        set_a(1'b1, 1'b1, 2'b01, 4'd7, 16'hABCD); step();
        set_a(1'b1, 1'b0, 2'b00, 4'd7, '0);       step();
        chk("byte enable merge", doa_w[0], 16'h12CD);

        // read-during-write modes
        set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'h1111); step();
        idle(); repeat (2) step();
        set_a(1'b1, 1'b1, 2'b11, 4'd3, 16'h2222); step();
        chk("read_first dout", doa_w[0], 16'h1111);
        chk("no_change dvalid", DW'(dva_w[2]), 16'd0);
        chk("no_change dout held", doa_w[2], 16'h12CD);
        idle(); step();
        chk("write_first dout", doa_w[1], 16'h2222);

        // dual write to one address, then cross-port read-first
        set_a(1'b1, 1'b1, 2'b10, 4'd9, 16'hAAAA);
        set_b(1'b1, 1'b1, 2'b11, 4'd9, 16'hBBBB); step();
        chk("dual write collision", DW'(coll_w[0]), 16'd1);
        idle(); set_a(1'b1, 1'b0, 2'b00, 4'd9, '0); step();
        chk("dual write word", doa_w[0], 16'hAABB);
        chk("collision one cycle", DW'(coll_w[0]), 16'd0);
        set_b(1'b1, 1'b1, 2'b11, 4'd9, 16'h5555); step();
        chk("cross read old word", doa_w[0], 16'hAABB);
        chk("read/write collision", DW'(coll_w[0]), 16'd1);
        set_b(1'b1, 1'b0, 2'b00, 4'd9, '0); step();
        chk("both read no collision", DW'(coll_w[0]), 16'd0);
        set_a(1'b1, 1'b1, 2'b00, 4'd9, 16'hFFFF); step();
        chk("be=0 write is no collision", DW'(coll_w[0]), 16'd0);
        idle(); step();

        // random traffic on a narrow address window to provoke conflicts
        repeat (400) begin rnd(); step(); end

        // reset while ready, then reset in the middle of the clear
        do_reset();
        chk("reset dout_a", doa_w[0], 16'h0000);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) begin rnd(); step(); end
        do_reset();
        chk("mid-clear reset init_done", DW'(idn_w[0]), 16'd0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rnd(); step();
            if (i == 14) chk("restart clear not done", DW'(idn_w[0]), 16'd0);
        end
        chk("restart clear done", DW'(idn_w[0]), 16'd1);
        sweep();
        repeat (100) begin rnd(); step(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
